// File: rtl/divider_nx4_seq.sv
// Sequential restoring divider: (N+4)-bit unsigned dividend by 4-bit unsigned divisor,
// one quotient bit per clock, with start/busy/done handshake and divide-by-zero flag.
module divider_nx4_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N+3:0]   dividend,
    input  logic [3:0]     divisor,
    output logic           busy,
    output logic           done,
    output logic [N+3:0]   quotient,
    output logic [3:0]     remainder,
    output logic           dbz
);

    localparam int W  = N + 4;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_pr;
    logic [3:0]      w_pr_nxt;
    logic [W-1:0]    r_dq;
    logic [W-1:0]    w_dq_nxt;
    logic [3:0]      r_dvs;
    logic [3:0]      w_dvs_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [W-1:0]    r_quot;
    logic [W-1:0]    w_quot_nxt;
    logic [3:0]      r_rem;
    logic [3:0]      w_rem_nxt;
    logic            r_dbz;
    logic            w_dbz_nxt;
    logic            r_busy;
    logic            r_done;

    logic [4:0]      w_trial;
    logic            w_qbit;
    logic [3:0]      w_pr_step;
    logic [W-1:0]    w_dq_step;

    // One restoring step. The partial remainder stays below the divisor, so
    // a successful subtraction always fits in 4 bits.
    function automatic logic [4:0] f_restore(input logic [4:0] trial, input logic [3:0] dvs);
        logic [3:0] diff;
        diff = trial[3:0] - dvs;
        if (trial >= {1'b0, dvs}) begin
            f_restore = {1'b1, diff};
        end else begin
            f_restore = {1'b0, trial[3:0]};
        end
    endfunction

    assign w_trial   = {r_pr, r_dq[W-1]};
    assign {w_qbit, w_pr_step} = f_restore(w_trial, r_dvs);
    assign w_dq_step = {r_dq[W-2:0], w_qbit};

    // Next-state and datapath update for the IDLE/RUN/DONE controller.
    always_comb begin
        w_state_nxt = r_state;
        w_pr_nxt    = r_pr;
        w_dq_nxt    = r_dq;
        w_dvs_nxt   = r_dvs;
        w_cnt_nxt   = r_cnt;
        w_quot_nxt  = r_quot;
        w_rem_nxt   = r_rem;
        w_dbz_nxt   = r_dbz;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (divisor != 4'd0) begin
                        w_state_nxt = S_RUN;
                        w_pr_nxt    = 4'd0;
                        w_dq_nxt    = dividend;
                        w_dvs_nxt   = divisor;
                        w_cnt_nxt   = CW'(W);
                    end else begin
                        w_state_nxt = S_DONE;
                        w_quot_nxt  = {W{1'b1}};
                        w_rem_nxt   = 4'd0;
                        w_dbz_nxt   = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                w_pr_nxt  = w_pr_step;
                w_dq_nxt  = w_dq_step;
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_DONE;
                    w_quot_nxt  = w_dq_step;
                    w_rem_nxt   = w_pr_step;
                    w_dbz_nxt   = 1'b0;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, working registers and committed results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pr    <= 4'd0;
            r_dq    <= {W{1'b0}};
            r_dvs   <= 4'd0;
            r_cnt   <= {CW{1'b0}};
            r_quot  <= {W{1'b0}};
            r_rem   <= 4'd0;
            r_dbz   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pr    <= w_pr_nxt;
            r_dq    <= w_dq_nxt;
            r_dvs   <= w_dvs_nxt;
            r_cnt   <= w_cnt_nxt;
            r_quot  <= w_quot_nxt;
            r_rem   <= w_rem_nxt;
            r_dbz   <= w_dbz_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign dbz       = r_dbz;

endmodule

// File: tb/tb_divider_nx4_seq.sv
// Scoreboard bench for divider_nx4_seq with N=4 and N=8 instances.
module tb_divider_nx4_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, busy4, done4, dbz4;
    logic [7:0]  dd4, quo4;
    logic [3:0]  dv4, rem4;
    logic        start8, busy8, done8, dbz8;
    logic [11:0] dd8, quo8;
    logic [3:0]  dv8, rem8;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [11:0] dd;
        logic [3:0]  dv;
        logic [11:0] q;
        logic [3:0]  r;
        logic        z;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb4[$];
    exp_t sb8[$];
    exp_t e4, e8;

    divider_nx4_seq #(.N(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .dividend(dd4), .divisor(dv4),
        .busy(busy4), .done(done4), .quotient(quo4), .remainder(rem4), .dbz(dbz4)
    );

    divider_nx4_seq #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(dd8), .divisor(dv8),
        .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8), .dbz(dbz8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [11:0] dd, input logic [3:0] dv, input int acc);
        exp_t        e;
        logic [11:0] ones;
        ones  = 12'hFFF;
        e.dd  = dd;
        e.dv  = dv;
        e.acc = acc;
        if (dv == 4'd0) begin
            e.q   = ones >> (12 - w);
            e.r   = 4'd0;
            e.z   = 1'b1;
            e.lat = 0;
        end else begin
            e.q   = dd / {8'd0, dv};
            e.r   = 4'(dd % {8'd0, dv});
            e.z   = 1'b0;
            e.lat = w;
        end
        return e;
    endfunction

    // Result monitors: pop the oldest expectation on every done pulse.
    always @(negedge clk) begin : mon4
        if (!rst && done4) begin
            if (sb4.size() == 0) begin
                check("spurious_done4", 32'd1, 32'd0);
            end else begin
                e4 = sb4.pop_front();
                check("quot4", 32'(quo4), 32'(e4.q[7:0]));
                check("rem4", 32'(rem4), 32'(e4.r));
                check("dbz4", 32'(dbz4), 32'(e4.z));
                check("lat4", cyc - e4.acc, e4.lat);
                if (!e4.z) begin
                    check("inv4", 32'(quo4) * 32'(e4.dv) + 32'(rem4), 32'(e4.dd));
                    check("rlt4", 32'(rem4 < e4.dv), 32'd1);
                end
            end
        end
    end

    always @(negedge clk) begin : mon8
        if (!rst && done8) begin
            if (sb8.size() == 0) begin
                check("spurious_done8", 32'd1, 32'd0);
            end else begin
                e8 = sb8.pop_front();
                check("quot8", 32'(quo8), 32'(e8.q));
                check("rem8", 32'(rem8), 32'(e8.r));
                check("dbz8", 32'(dbz8), 32'(e8.z));
                check("lat8", cyc - e8.acc, e8.lat);
                if (!e8.z) begin
                    check("inv8", 32'(quo8) * 32'(e8.dv) + 32'(rem8), 32'(e8.dd));
                    check("rlt8", 32'(rem8 < e8.dv), 32'd1);
                end
            end
        end
    end

    task automatic go(input bit big, input logic [11:0] dd, input logic [3:0] dv);
        @(negedge clk);
        if (big) begin
            start8 = 1'b1; dd8 = dd; dv8 = dv;
            sb8.push_back(model(12, dd, dv, cyc + 1));
        end else begin
            start4 = 1'b1; dd4 = dd[7:0]; dv4 = dv;
            sb4.push_back(model(8, {4'd0, dd[7:0]}, dv, cyc + 1));
        end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic wait_idle(input bit big);
        int k;
        k = 0;
        while (((big ? sb8.size() : sb4.size()) != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (big && sb8.size() != 0) begin
            check("timeout8", sb8.size(), 0);
            sb8.delete();
        end else if (!big && sb4.size() != 0) begin
            check("timeout4", sb4.size(), 0);
            sb4.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        start4 = 1'b0; dd4 = 8'd0; dv4 = 4'd0;
        start8 = 1'b0; dd8 = 12'd0; dv8 = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_quot4", 32'(quo4), 32'd0);
        check("rst_rem4", 32'(rem4), 32'd0);
        check("rst_dbz4", 32'(dbz4), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_quot8", 32'(quo8), 32'd0);
        rst = 1'b0;

        go(1'b0, 12'd200, 4'd7);  wait_idle(1'b0);
        go(1'b0, 12'd255, 4'd1);  wait_idle(1'b0);
        go(1'b0, 12'd5,   4'd9);  wait_idle(1'b0);
        go(1'b0, 12'd255, 4'd15); wait_idle(1'b0);
        go(1'b0, 12'd100, 4'd0);  wait_idle(1'b0);
        go(1'b0, 12'd9,   4'd2);  wait_idle(1'b0);
        repeat (3) @(negedge clk);
        check("hold_idle_quot", 32'(quo4), 32'd4);
        check("hold_idle_rem", 32'(rem4), 32'd1);

        // Back-to-back start in DONE, then start held through the whole RUN.
        @(negedge clk);
        start4 = 1'b1; dd4 = 8'd200; dv4 = 4'd7;
        sb4.push_back(model(8, 12'd200, 4'd7, cyc + 1));
        @(negedge clk);
        start4 = 1'b0;
        k = 0;
        while (!done4 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("b2b_first_done", 32'(done4), 32'd1);
        start4 = 1'b1; dd4 = 8'd60; dv4 = 4'd4;
        sb4.push_back(model(8, 12'd60, 4'd4, cyc + 1));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start4 = 1'b1; dd4 = 8'(99 + i); dv4 = 4'd3;
            check("b2b_busy", 32'(busy4), 32'd1);
            check("b2b_hold_quot", 32'(quo4), 32'd28);
        end
        @(negedge clk);
        start4 = 1'b0;
        check("b2b_second_done", 32'(done4), 32'd1);
        wait_idle(1'b0);
        repeat (12) @(negedge clk);
        check("b2b_no_extra_op", 32'(busy4), 32'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        start4 = 1'b1; dd4 = 8'd200; dv4 = 4'd7;
        sb4.push_back(model(8, 12'd200, 4'd7, cyc + 1));
        @(negedge clk);
        start4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrun_busy", 32'(busy4), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy4), 32'd0);
        check("abort_done", 32'(done4), 32'd0);
        check("abort_quot", 32'(quo4), 32'd0);
        check("abort_rem", 32'(rem4), 32'd0);
        check("abort_dbz", 32'(dbz4), 32'd0);
        sb4.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_done", 32'(done4), 32'd0);
        go(1'b0, 12'd200, 4'd7); wait_idle(1'b0);

        for (int i = 0; i < 2000; i++) begin
            go(1'b0, 12'($urandom_range(0, 255)), 4'($urandom_range(1, 15)));
            wait_idle(1'b0);
        end
        for (int i = 0; i < 2000; i++) begin
            go(1'b1, 12'($urandom_range(0, 4095)), 4'($urandom_range(1, 15)));
            wait_idle(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
